wb_display_ctrl: RTL

Parametrised writeback display controller: generates the core clock-enable, buffers core writeback words in a DEPTH-entry FIFO, and shows each word in hex on a multiplexed NUM_DIGITS seven-segment display for a fixed hold time. It replaces the separate divider, buffer and GPIO chain with a single-clock block. The core runs on `clk` gated by `core_en`, so there is no derived clock.

---
 rtl/wb_display_pkg.sv | 37 +++
 rtl/sseg_scanner.sv | 75 +++++++
 rtl/wb_display_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_display_pkg.sv
// Shared constants and helpers for wb_display_ctrl: seven-segment blank code,
// hex-to-segment decode and the FIFO occupancy counter width.
package wb_display_pkg;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Active-low segment pattern for one hex nibble, decimal point off.
    function automatic logic [7:0] hex_to_sseg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = SSEG_BLANK;
        endcase
        return seg;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sseg_scanner.sv
// Multiplexed seven-segment scanner: steps one digit every SCAN_CYCLES clocks
// and registers the anode/cathode drive for the digit currently selected.
module sseg_scanner
    import wb_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [31:0]           disp_word,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [7:0]            SSEG_CA,
    output logic [NUM_DIGITS-1:0] SSEG_AN
);

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]         scan_cnt_r;
    logic [IW-1:0]         scan_idx_r;
    logic [3:0]            nibble_s;
    logic                  dp_on_s;
    logic [NUM_DIGITS-1:0] an_s;
    logic [7:0]            ca_s;
    logic [7:0]            ca_r;
    logic [NUM_DIGITS-1:0] an_r;

    // Per-digit dwell timer and digit index
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            if (scan_idx_r == IDX_LAST) begin
                scan_idx_r <= '0;
            end else begin
                scan_idx_r <= scan_idx_r + IW'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Select the nibble, anode and decimal point for the current digit
    always_comb begin
        nibble_s = 4'(disp_word >> {scan_idx_r, 2'b00});
        an_s     = '1;
        dp_on_s  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_s[i] = (scan_idx_r == IW'(i)) ? 1'b0 : 1'b1;
            dp_on_s = dp_on_s | (dp_mask[i] & ~an_s[i]);
        end
        // Decode leaves bit 7 high, so masking it is enough to light the DP.
        ca_s = hex_to_sseg(nibble_s) & {~dp_on_s, 7'h7F};
    end

    // Registered pad drive
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ca_r <= SSEG_BLANK;
            an_r <= '1;
        end else begin
            ca_r <= ca_s;
            an_r <= an_s;
        end
    end

    assign SSEG_CA = ca_r;
    assign SSEG_AN = an_r;

endmodule

// File: rtl/wb_display_ctrl.sv
// Writeback display controller: core clock-enable divider, writeback FIFO,
// hold-time pacing and hex display. Optional macro: WB_DISPLAY_BACKPRESSURE_EN.
module wb_display_ctrl
    import wb_display_pkg::*;
#(
    parameter int DIV         = 9,
    parameter int DEPTH       = 16,
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_CYCLES = 1000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wb_valid,
    input  logic [31:0]            wb_data,
    output logic                   core_en,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             SSEG_CA,
    output logic [NUM_DIGITS-1:0]  SSEG_AN
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_count_width(DEPTH);
    localparam int DW = $clog2(DIV);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [DW-1:0]         div_cnt_r;
    logic                  core_en_r;
    logic [31:0]           mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic [HW-1:0]         hold_cnt_r;
    logic [31:0]           disp_word_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  hold_done_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  div_top_s;
    logic                  div_stall_s;
    logic [NUM_DIGITS-1:0] dp_mask_s;

    // FIFO handshake; a full FIFO still accepts a word when it pops the same cycle
    always_comb begin
        full_s      = (count_r == COUNT_FULL);
        empty_s     = (count_r == '0);
        hold_done_s = (hold_cnt_r == HOLD_LAST);
        pop_s       = hold_done_s & ~empty_s;
        push_s      = wb_valid & (~full_s | pop_s);
        drop_s      = wb_valid & full_s & ~pop_s;
        div_top_s   = (div_cnt_r == DIV_LAST);
`ifdef WB_DISPLAY_BACKPRESSURE_EN
        div_stall_s = full_s;
`else
        div_stall_s = 1'b0;
`endif
    end

    // Clock-enable divider; a stalled divider parks at its last count
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            div_cnt_r <= '0;
            core_en_r <= 1'b0;
        end else if (div_top_s && div_stall_s) begin
            div_cnt_r <= div_cnt_r;
            core_en_r <= 1'b0;
        end else if (div_top_s) begin
            div_cnt_r <= '0;
            core_en_r <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
            core_en_r <= 1'b0;
        end
    end

    // Storage array; contents need no reset because count_r gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wb_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Hold timer; it rests saturated so an idle display takes the next word at once
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hold_cnt_r  <= HOLD_LAST;
            disp_word_r <= 32'h0000_0000;
        end else if (pop_s) begin
            hold_cnt_r  <= '0;
            disp_word_r <= mem_r[rd_ptr_r];
        end else if (!hold_done_s) begin
            hold_cnt_r  <= hold_cnt_r + HW'(1);
            disp_word_r <= disp_word_r;
        end else begin
            hold_cnt_r  <= hold_cnt_r;
            disp_word_r <= disp_word_r;
        end
    end

    // Only digit 0 carries the overflow indicator
    always_comb begin
        dp_mask_s    = '0;
        dp_mask_s[0] = overflow_r;
    end

    sseg_scanner #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_scanner (
        .clk       (clk),
        .n_rst     (n_rst),
        .disp_word (disp_word_r),
        .dp_mask   (dp_mask_s),
        .SSEG_CA   (SSEG_CA),
        .SSEG_AN   (SSEG_AN)
    );

    assign core_en    = core_en_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule
